// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_write_arbiter
// Brief    : Shares the register-file write port between WB, LLU and debug;
//            keeps the LLU pending-write scoreboard and the RAW stall.
//            Optional debug port enabled by defining RF_ARB_DEBUG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rf_write_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int WAIT_W   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        llu_valid,
    input  logic [4:0]  llu_rd,
    input  logic [31:0] llu_data,
    output logic        llu_ready,
    input  logic        llu_issue,
    input  logic [4:0]  llu_issue_rd,
    input  logic        dbg_valid,
    input  logic [4:0]  dbg_rd,
    input  logic [31:0] dbg_data,
    output logic        dbg_ready,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic [4:0]  dec_rd,
    output logic        raw_stall,
    output logic        pipe_hold,
    output logic [4:0]  rf_a3,
    output logic [31:0] rf_wd3,
    output logic        rf_we3,
    output logic [31:0] sb_busy,
    output logic        sb_err
);

`ifdef RF_ARB_DEBUG_EN
    localparam logic C_DBG_EN = 1'b1;
`else
    localparam logic C_DBG_EN = 1'b0;
`endif
    localparam logic [WAIT_W-1:0] C_MAX_WAIT = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] C_HOLD_AT  = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        HOLD = 2'b01,
        DBG  = 2'b10
    } state_t;

    state_t            state_q;
    logic              pipe_hold_q;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [31:0]       busy_q, busy_d;
    logic              err_q, err_d;

    logic        w_grant_wb, w_grant_llu, w_grant_dbg;
    logic        w_llu_wait, w_wait_hit;
    logic [31:0] w_set, w_clr;

    always_comb begin
        w_grant_wb  = wb_valid;
        w_grant_llu = 1'b0;
        w_grant_dbg = 1'b0;
        if (!wb_valid) begin
            if (C_DBG_EN && (state_q == DBG) && dbg_valid) begin
                w_grant_dbg = 1'b1;
            end else if (llu_valid) begin
                w_grant_llu = 1'b1;
            end else if (C_DBG_EN && dbg_valid) begin
                w_grant_dbg = 1'b1;
            end
        end
    end

    always_comb begin
        rf_a3  = 5'd0;
        rf_wd3 = 32'd0;
        if (w_grant_wb) begin
            rf_a3  = wb_rd;
            rf_wd3 = wb_data;
        end else if (w_grant_llu) begin
            rf_a3  = llu_rd;
            rf_wd3 = llu_data;
        end else if (w_grant_dbg) begin
            rf_a3  = dbg_rd;
            rf_wd3 = dbg_data;
        end
    end

    // x0 writes still complete their handshake but never reach the array
    assign rf_we3    = (w_grant_wb | w_grant_llu | w_grant_dbg) & (rf_a3 != 5'd0);
    assign llu_ready = w_grant_llu;
    assign dbg_ready = w_grant_dbg;

    assign w_llu_wait = llu_valid & ~w_grant_llu;
    // >= also catches a count that saturated while debug owned the port
    assign w_wait_hit = w_llu_wait & (wait_q >= C_HOLD_AT);
    assign wait_d     = !w_llu_wait ? '0 :
                        (wait_q == C_MAX_WAIT) ? wait_q : wait_q + 1'b1;

    assign w_set  = (llu_issue && (llu_issue_rd != 5'd0)) ? (32'd1 << llu_issue_rd) : 32'd0;
    assign w_clr  = w_grant_llu ? (32'd1 << llu_rd) : 32'd0;
    assign busy_d = ((busy_q & ~w_clr) | w_set) & ~32'd1;
    assign err_d  = err_q | (|(w_set & busy_q));

    assign raw_stall = ((dec_rs1 != 5'd0) & busy_q[dec_rs1]) |
                       ((dec_rs2 != 5'd0) & busy_q[dec_rs2]) |
                       ((dec_rd  != 5'd0) & busy_q[dec_rd]);

    assign pipe_hold = pipe_hold_q;
    assign sb_busy   = busy_q;
    assign sb_err    = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            pipe_hold_q <= 1'b0;
            wait_q      <= '0;
            busy_q      <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            wait_q <= wait_d;
            busy_q <= busy_d;
            err_q  <= err_d;
            case (state_q)
                RUN: begin
`ifdef RF_ARB_DEBUG_EN
                    if (dbg_valid) begin
                        state_q     <= DBG;
                        pipe_hold_q <= 1'b1;
                    end else
`endif
                    if (w_wait_hit) begin
                        state_q     <= HOLD;
                        pipe_hold_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (w_grant_llu) begin
                        state_q     <= RUN;
                        pipe_hold_q <= 1'b0;
                    end
                end
`ifdef RF_ARB_DEBUG_EN
                DBG: begin
                    if (w_grant_dbg || !dbg_valid) begin
                        state_q     <= RUN;
                        pipe_hold_q <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_q     <= RUN;
                    pipe_hold_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_write_arbiter
// Brief    : Directed and randomized bench for rf_write_arbiter against a
//            behavioural model of the write-port sharing rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_write_arbiter;

    localparam int MAX_WAIT = 4;
`ifdef RF_ARB_DEBUG_EN
    localparam bit DBG_ON = 1'b1;
`else
    localparam bit DBG_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid, llu_valid, llu_issue, dbg_valid;
    logic [4:0]  wb_rd, llu_rd, llu_issue_rd, dbg_rd, dec_rs1, dec_rs2, dec_rd;
    logic [31:0] wb_data, llu_data, dbg_data;
    logic        llu_ready, dbg_ready, raw_stall, pipe_hold, rf_we3, sb_err;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd3, sb_busy;

    rf_write_arbiter #(.MAX_WAIT(MAX_WAIT), .WAIT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .llu_valid(llu_valid), .llu_rd(llu_rd), .llu_data(llu_data), .llu_ready(llu_ready),
        .llu_issue(llu_issue), .llu_issue_rd(llu_issue_rd),
        .dbg_valid(dbg_valid), .dbg_rd(dbg_rd), .dbg_data(dbg_data), .dbg_ready(dbg_ready),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .raw_stall(raw_stall), .pipe_hold(pipe_hold),
        .rf_a3(rf_a3), .rf_wd3(rf_wd3), .rf_we3(rf_we3),
        .sb_busy(sb_busy), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: who owns the port is decided by plain priority over a mode flag.
    bit        m_hold, m_dbg, m_err;
    int        m_wait;
    bit [31:0] m_busy;
    int        win;          // 0 none, 1 WB, 2 LLU, 3 debug
    bit        last_llu_g, last_dbg_g;

    task automatic model_reset();
        m_hold = 0; m_dbg = 0; m_err = 0; m_wait = 0; m_busy = '0;
        last_llu_g = 0; last_dbg_g = 0;
    endtask

    function automatic int pick_winner();
        if (wb_valid) return 1;
        if (m_dbg && dbg_valid) return 3;
        if (llu_valid) return 2;
        if (DBG_ON && dbg_valid) return 3;
        return 0;
    endfunction

    function automatic bit busy_op(input logic [4:0] r);
        return (r != 0) && m_busy[r];
    endfunction

    task automatic settle();
        logic [4:0]  ea;
        logic [31:0] ed;
        #3;
        win = pick_winner();
        ea = 0; ed = 0;
        if (win == 1) begin ea = wb_rd;  ed = wb_data;  end
        if (win == 2) begin ea = llu_rd; ed = llu_data; end
        if (win == 3) begin ea = dbg_rd; ed = dbg_data; end
        check_eq("rf_a3", 32'(rf_a3), 32'(ea));
        check_eq("rf_wd3", rf_wd3, ed);
        check_eq("rf_we3", 32'(rf_we3), 32'(win != 0 && ea != 0));
        check_eq("llu_ready", 32'(llu_ready), 32'(win == 2));
        check_eq("dbg_ready", 32'(dbg_ready), 32'(win == 3));
        check_eq("raw_stall", 32'(raw_stall),
                 32'(busy_op(dec_rs1) || busy_op(dec_rs2) || busy_op(dec_rd)));
        check_eq("pipe_hold", 32'(pipe_hold), 32'(m_hold || m_dbg));
        check_eq("sb_busy", sb_busy, m_busy);
        check_eq("sb_err", 32'(sb_err), 32'(m_err));
    endtask

    task automatic advance();
        bit llu_g, dbg_g, waited;
        llu_g  = (win == 2);
        dbg_g  = (win == 3);
        waited = llu_valid && !llu_g;
        if (!m_hold && !m_dbg) begin
            if (DBG_ON && dbg_valid) m_dbg = 1;
            else if (waited && m_wait + 1 >= MAX_WAIT) m_hold = 1;
        end else if (m_hold) begin
            if (llu_g) m_hold = 0;
        end else begin
            if (dbg_g || !dbg_valid) m_dbg = 0;
        end
        m_wait = !waited ? 0 : (m_wait < MAX_WAIT ? m_wait + 1 : MAX_WAIT);
        if (llu_issue && llu_issue_rd != 0 && m_busy[llu_issue_rd]) m_err = 1;
        if (llu_g) m_busy[llu_rd] = 0;
        if (llu_issue && llu_issue_rd != 0) m_busy[llu_issue_rd] = 1;
        last_llu_g = llu_g;
        last_dbg_g = dbg_g;
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        settle();
        advance();
    endtask

    task automatic clear_inputs();
        wb_valid = 0; wb_rd = 0; wb_data = 0;
        llu_valid = 0; llu_rd = 0; llu_data = 0;
        llu_issue = 0; llu_issue_rd = 0;
        dbg_valid = 0; dbg_rd = 0; dbg_data = 0;
        dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
    endtask

    initial begin
        rst_n = 0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        settle();
        rst_n = 1;
        @(posedge clk);
        #1;

        // WB / LLU collision
        wb_valid = 1; wb_rd = 5; wb_data = 32'hAAAA0000;
        llu_valid = 1; llu_rd = 6; llu_data = 32'h66666666;
        settle();
        check_eq("coll_a3", 32'(rf_a3), 32'd5);
        check_eq("coll_wd3", rf_wd3, 32'hAAAA0000);
        check_eq("coll_llu_wait", 32'(llu_ready), 32'd0);
        advance();
        wb_valid = 0;
        settle();
        check_eq("coll_a3_llu", 32'(rf_a3), 32'd6);
        check_eq("coll_llu_gnt", 32'(llu_ready), 32'd1);
        advance();
        llu_valid = 0;

        // starvation guard
        wb_valid = 1; wb_rd = 2; wb_data = 32'h22222222;
        llu_valid = 1; llu_rd = 8; llu_data = 32'h88888888;
        for (int i = 0; i < 4; i++) begin
            settle();
            check_eq("starve_no_hold", 32'(pipe_hold), 32'd0);
            advance();
        end
        settle();
        check_eq("starve_hold", 32'(pipe_hold), 32'd1);
        advance();
        wb_valid = 0;
        settle();
        check_eq("starve_gnt", 32'(llu_ready), 32'd1);
        advance();
        llu_valid = 0;
        settle();
        check_eq("starve_release", 32'(pipe_hold), 32'd0);
        advance();

        // scoreboard and sticky error
        llu_issue = 1; llu_issue_rd = 7;
        cycle();
        dec_rs2 = 7;
        settle();
        check_eq("sb_raw", 32'(raw_stall), 32'd1);
        check_eq("sb_err_clean", 32'(sb_err), 32'd0);
        advance();
        llu_issue = 0;
        llu_valid = 1; llu_rd = 7; llu_data = 32'h77777777;
        settle();
        check_eq("sb_err_set", 32'(sb_err), 32'd1);
        check_eq("sb_raw_at_gnt", 32'(raw_stall), 32'd1);
        advance();
        llu_valid = 0;
        settle();
        check_eq("sb_raw_clear", 32'(raw_stall), 32'd0);
        advance();
        dec_rs2 = 0;

        // x0 writes
        wb_valid = 1; wb_rd = 0; wb_data = 32'hDEADBEEF;
        settle();
        check_eq("x0_wb_we", 32'(rf_we3), 32'd0);
        advance();
        wb_valid = 0;
        llu_valid = 1; llu_rd = 0; llu_data = 32'hCAFEF00D;
        settle();
        check_eq("x0_llu_rdy", 32'(llu_ready), 32'd1);
        check_eq("x0_llu_we", 32'(rf_we3), 32'd0);
        advance();
        llu_valid = 0;
        llu_issue = 1; llu_issue_rd = 0;
        cycle();
        llu_issue = 0;
        settle();
        check_eq("x0_issue_busy", sb_busy, 32'd0);
        advance();

        // debug port
        dbg_valid = 1; dbg_rd = 9; dbg_data = 32'h12345678;
`ifdef RF_ARB_DEBUG_EN
        llu_valid = 1; llu_rd = 10; llu_data = 32'hA0A0A0A0;
        settle();
        check_eq("dbg_run_llu", 32'(llu_ready), 32'd1);
        advance();
        llu_rd = 11; llu_data = 32'hB1B1B1B1;
        settle();
        check_eq("dbg_hold", 32'(pipe_hold), 32'd1);
        check_eq("dbg_rdy", 32'(dbg_ready), 32'd1);
        check_eq("dbg_wd3", rf_wd3, 32'h12345678);
        check_eq("dbg_llu_wait", 32'(llu_ready), 32'd0);
        advance();
        dbg_valid = 0;
        settle();
        check_eq("dbg_exit", 32'(pipe_hold), 32'd0);
        advance();
        llu_valid = 0;
`else
        for (int i = 0; i < 3; i++) begin
            settle();
            check_eq("dbg_off_rdy", 32'(dbg_ready), 32'd0);
            check_eq("dbg_off_hold", 32'(pipe_hold), 32'd0);
            advance();
        end
        dbg_valid = 0;
`endif

        // asynchronous reset in the middle of HOLD
        llu_issue = 1; llu_issue_rd = 7;
        cycle();
        llu_issue = 0;
        wb_valid = 1; wb_rd = 2; wb_data = 32'h0BADF00D;
        llu_valid = 1; llu_rd = 3; llu_data = 32'h33333333;
        repeat (5) cycle();
        settle();
        check_eq("rst_pre_hold", 32'(pipe_hold), 32'd1);
        check_eq("rst_pre_busy", sb_busy, 32'h80);
        rst_n = 0;
        #1;
        check_eq("rst_async_hold", 32'(pipe_hold), 32'd0);
        check_eq("rst_async_busy", sb_busy, 32'd0);
        model_reset();
        clear_inputs();
        @(posedge clk);
        #1;
        rst_n = 1;

        // randomized traffic obeying the hold-until-ready protocol
        for (int n = 0; n < 3000; n++) begin
            if (!llu_valid || last_llu_g) begin
                llu_valid = ($urandom_range(0, 99) < 40);
                llu_rd    = 5'($urandom_range(0, 15));
                llu_data  = $urandom;
            end
            if (!dbg_valid || last_dbg_g || $urandom_range(0, 9) == 0) begin
                dbg_valid = ($urandom_range(0, 99) < 15);
                dbg_rd    = 5'($urandom_range(0, 31));
                dbg_data  = $urandom;
            end
            wb_valid     = ($urandom_range(0, 99) < 55);
            wb_rd        = 5'($urandom_range(0, 31));
            wb_data      = $urandom;
            llu_issue    = ($urandom_range(0, 99) < 30);
            llu_issue_rd = 5'($urandom_range(0, 15));
            dec_rs1      = 5'($urandom_range(0, 15));
            dec_rs2      = 5'($urandom_range(0, 15));
            dec_rd       = 5'($urandom_range(0, 15));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Owns the single write port (a3/wd3/we3) of the core register file and shares it between three requesters: pipeline writeback (WB), the long-latency unit (LLU: loads/mul/div), and the debug register-write port.
- Keeps a per-register scoreboard of pending LLU writes and drives the decode-stage RAW stall.
- Includes a starvation guard that holds the pipeline so a waiting LLU or debug write gets a free write slot.

Parameters:
- MAX_WAIT, 4, number of consecutive cycles an LLU write may wait before the arbiter enters HOLD; legal range 1–15.
- WAIT_W, 4, width of the wait counter; must satisfy 2^WAIT_W > MAX_WAIT.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- wb_valid  in  1  WB write this cycle; never back-pressured.
- wb_rd  in  5  WB destination register.
- wb_data  in  32  WB write data.
- llu_valid  in  1  LLU result pending.
- llu_rd  in  5  LLU destination register.
- llu_data  in  32  LLU result.
- llu_ready  out  1  LLU write granted this cycle.
- llu_issue  in  1  LLU operation issued this cycle.
- llu_issue_rd  in  5  destination register of the issued op.
- dbg_valid  in  1  debug write request.
- dbg_rd  in  5  debug destination register.
- dbg_data  in  32  debug write data.
- dbg_ready  out  1  debug write granted this cycle.
- dec_rs1, dec_rs2, dec_rd  in  5 each  register operands of the instruction in decode.
- raw_stall  out  1  decode must stall.
- pipe_hold  out  1  registered; freeze issue so WB drains.
- rf_a3  out  5  register-file write address.
- rf_wd3  out  32  register-file write data.
- rf_we3  out  1  register-file write enable.
- sb_busy  out  32  scoreboard bits; bit 0 is always 0.
- sb_err  out  1  sticky flag: issue to a register that is already busy.

Behaviour:
- Grants are combinational from the current-cycle inputs. The register file samples on negedge, so the write lands in the same cycle as the grant.
- Priority: WB > (dbg if state==DBG else LLU) > the remaining one. At most one grant per cycle.
- Idle write port: rf_we3=0, rf_a3=0, rf_wd3=0.
- Writes to x0: the handshake completes (ready=1), but rf_we3 is forced to 0.
- The valid/ready handshake completes in any cycle where valid && ready. Requesters hold rd/data stable until ready.
- FSM states: RUN (2'b00), HOLD (2'b01), DBG (2'b10). State is exposed through pipe_hold only.
  - RUN → DBG when dbg_valid.
  - RUN → HOLD when an LLU wait occurs while wait_cnt==MAX_WAIT-1.
  - HOLD → RUN on an LLU grant.
  - DBG → RUN on a dbg grant.
  - If dbg_valid drops while in DBG, return to RUN.
- pipe_hold=1 in HOLD and DBG, registered (asserted the cycle after entry).
- Wait counter: counts cycles with llu_valid && !llu_ready; clears on an LLU grant or when llu_valid=0; saturates at MAX_WAIT.
- Scoreboard:
  - Set: llu_issue with llu_issue_rd!=0 sets busy[rd] at the next posedge.
  - Clear: an LLU grant clears busy[llu_rd].
  - Same register set and cleared in the same cycle: set wins.
  - A set on an already-busy bit also sets sb_err, which is sticky until reset.
- raw_stall = busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd], each term only when the operand is nonzero. WAW is included.
- Reset (asynchronous, any time, including mid-handshake): state=RUN, wait_cnt=0, sb_busy=0, sb_err=0, pipe_hold=0. Pending requests are not remembered; requesters re-present them.

Optional Feature:
- Macro: RF_ARB_DEBUG_EN.
- Defined: the debug port and DBG state behave as described above.
- Undefined:
  - DBG state is absent.
  - dbg_ready is tied to 0 and dbg_valid/dbg_rd/dbg_data are ignored.
  - pipe_hold is driven only by HOLD.

Test Plan:
- Collision: wb_valid=1 (rd=5, 0xAAAA0000) and llu_valid=1 (rd=6) in the same cycle → rf_a3=5, rf_wd3=0xAAAA0000, llu_ready=0; next cycle with wb_valid=0 → rf_a3=6, llu_ready=1.
- Starvation with MAX_WAIT=4: wb_valid held at 1 and llu_valid=1 for 4 cycles → pipe_hold=1 from the 5th cycle. Drop wb_valid → LLU granted, pipe_hold=0 the cycle after.
- Scoreboard: llu_issue rd=7, then dec_rs2=7 → raw_stall=1 until LLU rd=7 is granted, then 0 the next cycle. A second issue to rd=7 while busy → sb_err=1.
- x0 writes: wb rd=0 → rf_we3=0. LLU rd=0 → llu_ready=1, rf_we3=0. Issue rd=0 → sb_busy[0] stays 0.
- Debug (RF_ARB_DEBUG_EN defined): dbg_valid=1 rd=9 0x12345678 alongside llu_valid=1 and wb idle → DBG entered, dbg_ready=1, rf_wd3=0x12345678, LLU waits. With the macro undefined → dbg_ready stays 0.
- Reset: assert rst_n=0 mid-HOLD with sb_busy=0x80 → pipe_hold=0 and sb_busy=0 immediately, with no clock edge required.
